regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 171 +++++++++++++++++
 tb/tb_regfile_sb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with three combinational read ports, two write
// ports (port 0 = ALU result, port 1 = load return) and per-register busy
// tracking for loads still in flight.
//
// Address 15 always reads back i_R15 (the PC). Addresses at or above
// RegisterFileSize read 0; writes and reserves to them are dropped.
//
// Optional feature, selected by the macro REGFILE_BYPASS_EN:
//   defined   - a read of an address written this cycle returns the incoming
//               write data (port 0 over port 1). A port-1 write also hides
//               that register's busy bit in the same cycle, unless the same
//               cycle reserves it again.
//   undefined - reads see stored values only. New data and cleared busy bits
//               appear one cycle after the write edge.
module regfile_sb #(
    parameter int BusWidth         = 32,
    parameter int RegisterFileSize = 15
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [3:0]          i_Address_ToRead1,
    input  logic [3:0]          i_Address_ToRead2,
    input  logic [3:0]          i_Address_ToRead3,
    output logic [BusWidth-1:0] o_Read_Data1,
    output logic [BusWidth-1:0] o_Read_Data2,
    output logic [BusWidth-1:0] o_Read_Data3,

    input  logic                i_Write_Enable0,
    input  logic [3:0]          i_Address_ToWrite0,
    input  logic [BusWidth-1:0] i_Write_Data0,

    input  logic                i_Write_Enable1,
    input  logic [3:0]          i_Address_ToWrite1,
    input  logic [BusWidth-1:0] i_Write_Data1,

    input  logic [BusWidth-1:0] i_R15,

    input  logic                i_Reserve_Enable,
    input  logic [3:0]          i_Address_ToReserve,

    output logic                o_Busy1,
    output logic                o_Busy2,
    output logic                o_Busy3,
    output logic [3:0]          o_Pending_Count
);

    localparam int NumReadPorts = 3;
    localparam logic [3:0] PcAddr = 4'hF;

    // Storage and busy state
    logic [BusWidth-1:0]         mem [RegisterFileSize];
    logic [RegisterFileSize-1:0] busy_q;
    logic [RegisterFileSize-1:0] busy_d;
    logic [3:0]                  pending_q;
    logic [3:0]                  pending_d;

    // One-hot per-register strobes. Address 15 and out-of-range addresses
    // never match a stored index, so they decode to all-zero and are dropped.
    logic [RegisterFileSize-1:0] wr0_hit;
    logic [RegisterFileSize-1:0] wr1_hit;
    logic [RegisterFileSize-1:0] rsv_hit;

    // Read-port plumbing, indexed 0..2 for ports 1..3
    logic [3:0]          rd_addr [NumReadPorts];
    logic [BusWidth-1:0] rd_data [NumReadPorts];
    logic                rd_busy [NumReadPorts];

    assign rd_addr[0] = i_Address_ToRead1;
    assign rd_addr[1] = i_Address_ToRead2;
    assign rd_addr[2] = i_Address_ToRead3;

    assign o_Read_Data1 = rd_data[0];
    assign o_Read_Data2 = rd_data[1];
    assign o_Read_Data3 = rd_data[2];
    assign o_Busy1      = rd_busy[0];
    assign o_Busy2      = rd_busy[1];
    assign o_Busy3      = rd_busy[2];

    assign o_Pending_Count = pending_q;

    // Decode write-port and reserve addresses into per-register strobes
    always_comb begin
        // NOTE: every always_comb output gets a default before any condition;
        // a path that leaves one unassigned infers a latch.
        wr0_hit = '0;
        wr1_hit = '0;
        rsv_hit = '0;
        for (int i = 0; i < RegisterFileSize; i++) begin
            wr0_hit[i] = i_Write_Enable0  && (i_Address_ToWrite0  == 4'(i));
            wr1_hit[i] = i_Write_Enable1  && (i_Address_ToWrite1  == 4'(i));
            rsv_hit[i] = i_Reserve_Enable && (i_Address_ToReserve == 4'(i));
        end
    end

    // Next busy vector and its population count. A port-1 write clears the
    // bit and a reserve sets it; the reserve is applied last so it wins.
    always_comb begin
        busy_d    = (busy_q & ~wr1_hit) | rsv_hit;
        pending_d = '0;
        for (int i = 0; i < RegisterFileSize; i++) begin
            pending_d = pending_d + {3'b000, busy_d[i]};
        end
    end

    // Register storage: port 0 has priority over port 1 on the same address
    always_ff @(posedge clk) begin
        // NOTE: the storage array is cleared on reset because stored registers
        // must read 0 afterwards. That keeps it as flops rather than RAM,
        // which is the right choice for a 15-entry file.
        if (rst) begin
            for (int i = 0; i < RegisterFileSize; i++) begin
                // NOTE: clocked state uses non-blocking assignment so every
                // flop samples values from before the edge.
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RegisterFileSize; i++) begin
                if (wr0_hit[i]) begin
                    mem[i] <= i_Write_Data0;
                end else if (wr1_hit[i]) begin
                    mem[i] <= i_Write_Data1;
                end
            end
        end
    end

    // Busy bits and the registered pending count, updated together
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    // Combinational read mux for each port: PC, stored value or zero.
    // Busy reads 0 for address 15 and for out-of-range addresses.
    always_comb begin
        for (int p = 0; p < NumReadPorts; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (rd_addr[p] == PcAddr) begin
                rd_data[p] = i_R15;
            end
            for (int i = 0; i < RegisterFileSize; i++) begin
                if (rd_addr[p] == 4'(i)) begin
                    rd_data[p] = mem[i];
                    rd_busy[p] = busy_q[i];
`ifdef REGFILE_BYPASS_EN
                    // Forward same-cycle writes. Reset discards them, so
                    // nothing is forwarded while rst is high.
                    if (!rst) begin
                        if (wr0_hit[i]) begin
                            rd_data[p] = i_Write_Data0;
                        end else if (wr1_hit[i]) begin
                            rd_data[p] = i_Write_Data1;
                        end
                        if (wr1_hit[i] && !rsv_hit[i]) begin
                            rd_busy[p] = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb. A behavioural model of the
// register file is updated on each rising edge. A compare process checks all
// seven outputs against that model on every falling edge. Literal
// expectations in the main sequence pin the model itself.
// Builds with or without REGFILE_BYPASS_EN to match the design under test.
module tb_regfile_sb;

    localparam int Size = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra1, ra2, ra3;
    logic [31:0] rd1, rd2, rd3;
    logic        we0, we1, rsv;
    logic [3:0]  wa0, wa1, rsva;
    logic [31:0] wd0, wd1, r15;
    logic        bz1, bz2, bz3;
    logic [3:0]  pcount;

    int   n_pass  = 0;
    int   n_total = 0;
    logic cmp_en  = 1'b0;

    // Behavioural model state (index 15 is never a stored register)
    logic [31:0] m_mem  [16];
    bit          m_busy [16];

    regfile_sb #(.BusWidth(32), .RegisterFileSize(Size)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_Address_ToRead1   (ra1),
        .i_Address_ToRead2   (ra2),
        .i_Address_ToRead3   (ra3),
        .o_Read_Data1        (rd1),
        .o_Read_Data2        (rd2),
        .o_Read_Data3        (rd3),
        .i_Write_Enable0     (we0),
        .i_Address_ToWrite0  (wa0),
        .i_Write_Data0       (wd0),
        .i_Write_Enable1     (we1),
        .i_Address_ToWrite1  (wa1),
        .i_Write_Data1       (wd1),
        .i_R15               (r15),
        .i_Reserve_Enable    (rsv),
        .i_Address_ToReserve (rsva),
        .o_Busy1             (bz1),
        .o_Busy2             (bz2),
        .o_Busy3             (bz3),
        .o_Pending_Count     (pcount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Expected read data from the model, including same-cycle forwarding
    function automatic logic [31:0] exp_data(input logic [3:0] a);
        if (a == 4'd15) return r15;
        if (int'(a) >= Size) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && we0 && wa0 == a) return wd0;
        if (!rst && we1 && wa1 == a) return wd1;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        if (int'(a) >= Size) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && we1 && wa1 == a && !(rsv && rsva == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < Size; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Model update at each rising edge: reset first, then writes, clear, reserve
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we1 && int'(wa1) < Size) begin
                m_mem[wa1]  = wd1;
                m_busy[wa1] = 1'b0;
            end
            if (we0 && int'(wa0) < Size) m_mem[wa0] = wd0;
            if (rsv && int'(rsva) < Size) m_busy[rsva] = 1'b1;
        end
    end

    // Compare all outputs against the model away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_rd1",   rd1, exp_data(ra1));
            check("cmp_rd2",   rd2, exp_data(ra2));
            check("cmp_rd3",   rd3, exp_data(ra3));
            check("cmp_busy1", {31'b0, bz1}, {31'b0, exp_busy(ra1)});
            check("cmp_busy2", {31'b0, bz2}, {31'b0, exp_busy(ra2)});
            check("cmp_busy3", {31'b0, bz3}, {31'b0, exp_busy(ra3)});
            check("cmp_count", {28'b0, pcount}, 32'(exp_count()));
        end
    end

    task automatic idle();
        we0 = 1'b0; wa0 = 4'd0; wd0 = 32'h0;
        we1 = 1'b0; wa1 = 4'd0; wd1 = 32'h0;
        rsv = 1'b0; rsva = 4'd0;
    endtask

    task automatic reads(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
        ra1 = a1; ra2 = a2; ra3 = a3;
    endtask

    // Apply one rising edge; inputs may change 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reads(4'd0, 4'd0, 4'd0);
        r15 = 32'h0000_0100;
        rst = 1'b1;
        step();
        cmp_en = 1'b1;
        step();

        // Reset state: stored registers 0, PC passthrough, no busy, count 0
        reads(4'd3, 4'd15, 4'd7);
        #1;
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd15_during", rd2, 32'h100);
        check("rst_busy", {29'b0, bz1, bz2, bz3}, 32'h0);
        check("rst_count", {28'b0, pcount}, 32'h0);
        rst = 1'b0;

        // Port-0 write of R3, then read it back and read the PC
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF;
        step(); idle();
        #1;
        check("r3_data", rd1, 32'hDEAD_BEEF);
        check("r15_data", rd2, 32'h100);

        // Both ports write R5: port 0 wins
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22;
        step(); idle();
        reads(4'd5, 4'd3, 4'd15);
        #1;
        check("r5_port0_wins", rd1, 32'h11);

        // Reserve R2, then load-return into R2
        rsv = 1'b1; rsva = 4'd2;
        step(); idle();
        reads(4'd2, 4'd5, 4'd15);
        #1;
        check("r2_busy_set", {31'b0, bz1}, 32'h1);
        check("r2_count_1", {28'b0, pcount}, 32'h1);
        we1 = 1'b1; wa1 = 4'd2; wd1 = 32'h55;
        step(); idle();
        #1;
        check("r2_busy_clr", {31'b0, bz1}, 32'h0);
        check("r2_count_0", {28'b0, pcount}, 32'h0);
        check("r2_data", rd1, 32'h55);

        // Reserve R4; then reserve and load-return together (reserve wins);
        // then a second reserve of an already-busy register
        reads(4'd4, 4'd2, 4'd15);
        rsv = 1'b1; rsva = 4'd4;
        step(); idle();
        #1;
        check("r4_count_1", {28'b0, pcount}, 32'h1);
        rsv = 1'b1; rsva = 4'd4;
        we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h77;
        step(); idle();
        #1;
        check("r4_busy_kept", {31'b0, bz1}, 32'h1);
        check("r4_count_kept", {28'b0, pcount}, 32'h1);
        check("r4_data", rd1, 32'h77);
        rsv = 1'b1; rsva = 4'd4;
        step(); idle();
        #1;
        check("r4_rereserve_count", {28'b0, pcount}, 32'h1);
        check("r4_rereserve_busy", {31'b0, bz1}, 32'h1);

        // Same-cycle read of a register being written
        reads(4'd7, 4'd4, 4'd15);
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r7_same_cycle", rd1, 32'hA5);
`else
        check("r7_same_cycle", rd1, 32'h0);
`endif
        step(); idle();
        #1;
        check("r7_next_cycle", rd1, 32'hA5);

        // Address 15 writes/reserves are ignored; busy for 15 reads 0
        we0 = 1'b1; wa0 = 4'd15; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'hEEEE_EEEE;
        rsv = 1'b1; rsva = 4'd15;
        step(); idle();
        reads(4'd15, 4'd4, 4'd7);
        #1;
        check("a15_data", rd1, 32'h100);
        check("a15_busy", {31'b0, bz1}, 32'h0);
        check("a15_count", {28'b0, pcount}, 32'h1);

        // Reserve R1 and R6 (R4 still pending), then reset with a write to R1
        rsv = 1'b1; rsva = 4'd1;
        step();
        rsva = 4'd6;
        step(); idle();
        reads(4'd1, 4'd6, 4'd4);
        #1;
        check("pend3_count", {28'b0, pcount}, 32'h3);
        check("pend3_busy", {29'b0, bz1, bz2, bz3}, 32'h7);
        rst = 1'b1;
        we0 = 1'b1; wa0 = 4'd1; wd0 = 32'h9;
        rsv = 1'b1; rsva = 4'd5;
        step(); idle();
        rst = 1'b0;
        #1;
        check("rst_r1", rd1, 32'h0);
        check("rst_r4", rd3, 32'h0);
        check("rst_busy_all", {29'b0, bz1, bz2, bz3}, 32'h0);
        check("rst_count_0", {28'b0, pcount}, 32'h0);

        // Late load return after reset stores data only
        we1 = 1'b1; wa1 = 4'd1; wd1 = 32'h33;
        step(); idle();
        #1;
        check("late_load_data", rd1, 32'h33);
        check("late_load_busy", {31'b0, bz1}, 32'h0);
        check("late_load_count", {28'b0, pcount}, 32'h0);

        // Mixed traffic, checked each cycle by the compare process
        for (int n = 0; n < 60; n++) begin
            rst  = ($urandom_range(0, 24) == 0);
            we0  = 1'($urandom_range(0, 1));
            wa0  = 4'($urandom_range(0, 15));
            wd0  = $urandom;
            we1  = 1'($urandom_range(0, 1));
            wa1  = 4'($urandom_range(0, 15));
            wd1  = $urandom;
            rsv  = 1'($urandom_range(0, 1));
            rsva = 4'($urandom_range(0, 15));
            r15  = $urandom;
            reads(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
